harmonic_sequencer: RTL

Sequences the additive-synthesis datapath for one output sample. For each harmonic it reads the phase from the sample-position RAM, advances and wraps it, writes it back, addresses the sine LUT, and hands the LUT value to the scaling accumulator with a per-harmonic amplitude. At each sample-rate tick it emits one clipped, offset-binary 16-bit sample for the DAC SPI sender.

---
 rtl/addatone_pkg.sv | 40 ++++
 rtl/sample_tick_timer.sv | 28 ++
 rtl/harmonic_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/addatone_pkg.sv
// Shared constants, sequencer state encoding and output formatting for the additive-synthesis voice.
package addatone_pkg;

  localparam int SAMPLE_RATE     = 48000;
  localparam int SAMPLE_INTERVAL = 1500;
  localparam int LUT_SHIFT       = 5;
  localparam int NUM_HARMONICS   = 64;
  localparam int DIV_BIT         = 7;
  localparam int OUT_SHIFT       = 2;

  // DAC command byte: write-and-update channel A
  localparam logic [7:0] DAC_CMD_WRITE_UPDATE = 8'h30;

  typedef enum logic [3:0] {
    START,
    ADDR,
    POS,
    WRITE,
    LUT1,
    LUT2,
    ISSUE,
    DRAIN,
    HOLD
  } seq_state_t;

  // Scale, clip to signed 16 bits, then flip the MSB: same as adding 32768
  function automatic logic [15:0] to_offset_binary(input logic [31:0] total);
    logic signed [31:0] v;
    logic [15:0]        clipped;
    v = $signed(total) >>> OUT_SHIFT;
    if (v > 32'sd32767)
      clipped = 16'h7FFF;
    else if (v < -32'sd32768)
      clipped = 16'h8000;
    else
      clipped = v[15:0];
    return clipped ^ 16'h8000;
  endfunction

endpackage

// File: rtl/sample_tick_timer.sv
// Free-running 0..INTERVAL-1 counter; tick is high for the final count of each interval.
module sample_tick_timer
  import addatone_pkg::*;
#(
  parameter int INTERVAL = SAMPLE_INTERVAL
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = $clog2(INTERVAL);
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (count == LAST)
      count <= '0;
    else
      count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample additive-synthesis sequencer: phase RAM update, sine LUT addressing, accumulator issue, DAC sample.
// At least 6 clocks per harmonic; stalls in ISSUE/DRAIN while acc_ready is low, a late sample raises overrun.
module harmonic_sequencer
  import addatone_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [15:0]        frequency,
  input  logic [7:0]         harmonic_count,
  input  logic [DIV_BIT-1:0] scale_step,
  output logic [7:0]         sp_addr,
  output logic               sp_wr_en,
  output logic [15:0]        sp_wr_data,
  input  logic [15:0]        sp_rd_data,
  output logic [10:0]        lut_addr,
  output logic               acc_start,
  output logic               acc_clear,
  output logic [DIV_BIT-1:0] acc_mult,
  input  logic               acc_ready,
  input  logic [31:0]        acc_total,
  output logic [15:0]        sample_out,
  output logic               sample_valid,
  output logic               overrun
);

  localparam logic [16:0] NYQUIST = 17'(SAMPLE_RATE / 2);
  localparam logic [17:0] MODULUS = 18'(SAMPLE_RATE);

  seq_state_t         state, state_nxt;
  logic               tick;
  logic [15:0]        freq_q;
  logic [6:0]         count_q;
  logic [DIV_BIT-1:0] step_q;
  logic [6:0]         n;
  logic [16:0]        inc;
  logic [DIV_BIT-1:0] amp;
  logic [15:0]        pos_q;
  logic [15:0]        result_q;

  logic [6:0]         count_clamped;
  logic [17:0]        sum;
  logic [15:0]        pos_nxt;
  logic [16:0]        inc_nxt;
  logic [6:0]         n_nxt;
  logic [DIV_BIT-1:0] amp_nxt;
  logic               last_harmonic;

  sample_tick_timer #(.INTERVAL(SAMPLE_INTERVAL)) u_timer (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign count_clamped = (harmonic_count > 8'(NUM_HARMONICS)) ? 7'(NUM_HARMONICS) : harmonic_count[6:0];

  // inc stays below the Nyquist limit, so one conditional subtract wraps the phase
  assign sum     = {2'b00, sp_rd_data} + {1'b0, inc};
  assign pos_nxt = (sum >= MODULUS) ? 16'(sum - MODULUS) : sum[15:0];

  assign inc_nxt       = inc + {1'b0, freq_q};
  assign n_nxt         = n + 7'd1;
  assign amp_nxt       = (amp > step_q) ? amp - step_q : '0;
  assign last_harmonic = (n_nxt == count_q) || (inc_nxt >= NYQUIST);

  assign sp_addr    = {1'b0, n};
  assign sp_wr_data = pos_q;

  always_ff @(posedge clock) begin
    if (reset)
      state <= START;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sp_wr_en  = 1'b0;
    acc_start = 1'b0;
    acc_clear = 1'b0;
    case (state)
      START: begin
        acc_clear = !reset;
        // a fundamental already at Nyquist leaves every phase untouched
        if (count_clamped == 7'd0 || {1'b0, frequency} >= NYQUIST)
          state_nxt = DRAIN;
        else
          state_nxt = ADDR;
      end
      ADDR:  state_nxt = POS;
      POS:   state_nxt = WRITE;
      WRITE: begin
        sp_wr_en  = 1'b1;
        state_nxt = LUT1;
      end
      LUT1:  state_nxt = LUT2;
      LUT2:  state_nxt = ISSUE;
      ISSUE: begin
        if (acc_ready) begin
          acc_start = 1'b1;
          state_nxt = last_harmonic ? DRAIN : ADDR;
        end
      end
      DRAIN: if (acc_ready) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = START;
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      freq_q       <= '0;
      count_q      <= '0;
      step_q       <= '0;
      n            <= '0;
      inc          <= '0;
      amp          <= '0;
      pos_q        <= '0;
      result_q     <= 16'h8000;
      lut_addr     <= '0;
      acc_mult     <= '0;
      sample_out   <= 16'h8000;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // a tick outside HOLD repeats the previous sample and flags the miss
      sample_valid <= tick;
      overrun      <= tick && (state != HOLD);
      case (state)
        START: begin
          freq_q  <= frequency;
          count_q <= count_clamped;
          step_q  <= scale_step;
          n       <= '0;
          inc     <= {1'b0, frequency};
          amp     <= '1;
        end
        POS: begin
          pos_q    <= pos_nxt;
          lut_addr <= 11'(pos_nxt >> LUT_SHIFT);
        end
        LUT2: acc_mult <= amp;
        ISSUE: begin
          if (acc_ready) begin
            amp <= amp_nxt;
            inc <= inc_nxt;
            n   <= n_nxt;
          end
        end
        DRAIN: if (acc_ready) result_q <= to_offset_binary(acc_total);
        HOLD:  if (tick) sample_out <= result_q;
        default: ;
      endcase
    end
  end

endmodule
